// File: rtl/video_in_2_stream.sv
// video_in_2_stream: parallel RGB video port (r/g/b, vsync, active) to a
// 16-bit AXI-Stream video stream (tuser = start of frame, tlast = end of line).
// The input is registered once. A one-pixel pending slot holds each pixel until
// the next cycle shows whether it ends the line. An output FIFO with
// first-word fall-through absorbs tready back-pressure.
// Optional feature macro: VIN_FRAME_COUNT_EN adds a 16-bit frame_cnt output
// that counts pushed start-of-frame pixels.
//
// Stream handshake: a beat transfers on every rising hclk edge where
// tvalid_m && tready_m. While tvalid_m is high and tready_m is low, tdata_m,
// tuser_m and tlast_m stay stable. tvalid_m never drops without a transfer.
module video_in_2_stream #(
  parameter int FIFO_DEPTH = 16,
  parameter bit VSYNC_POL  = 1'b1
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [4:0]                    vin_r,
  input  logic [4:0]                    vin_g,
  input  logic [5:0]                    vin_b,
  input  logic                          vin_vsync,
  input  logic                          vin_active,
  output logic [15:0]                   tdata_m,
  output logic                          tuser_m,
  output logic                          tlast_m,
  output logic                          tvalid_m,
  input  logic                          tready_m,
  output logic                          overflow,
`ifdef VIN_FRAME_COUNT_EN
  output logic [15:0]                   frame_cnt,
`endif
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  // state is the observable FSM state for checkers
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t state;

  // input stage; vsync is normalised to "asserted" so the edge logic is polarity-free
  logic [15:0] s1_data;
  logic        s1_active;
  logic        s1_vs;
  logic        s1_vs_prev;
  logic        vsync_edge;

  // pending slot and frame bookkeeping
  logic [15:0] pend_data;
  logic        pend_valid;
  logic        sof_arm;
  logic        overflow_q;

  // FIFO
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [17:0]   rd_entry;

  // write request from the pending slot
  logic          wr_req;
  logic          wr_tlast;
  logic          wr_tuser;

  assign vsync_edge = s1_vs && !s1_vs_prev;
  assign full       = (count == DEPTH_C);
  assign tvalid_m   = (count != '0);
  assign pop        = tvalid_m && tready_m;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push       = wr_req && (!full || pop);
  assign drop       = wr_req && full && !pop;
  assign rd_entry   = mem[rd_ptr];
  assign fifo_level = count;
  assign overflow   = overflow_q;

  // outputs read zero while the FIFO is empty so nothing is undefined after reset
  assign {tuser_m, tlast_m, tdata_m} = tvalid_m ? rd_entry : 18'd0;

  // register every video input each cycle
  always_ff @(posedge hclk) begin
    if (hreset) begin
      s1_data    <= 16'd0;
      s1_active  <= 1'b0;
      s1_vs      <= 1'b0;
      s1_vs_prev <= 1'b0;
    end else begin
      s1_data    <= {vin_r, vin_g, vin_b};
      s1_active  <= vin_active;
      s1_vs      <= (vin_vsync == VSYNC_POL);
      s1_vs_prev <= s1_vs;
    end
  end

  // a pending pixel always leaves the slot next cycle: as a mid-line pixel when
  // another pixel follows, otherwise as end of line (line end or vsync cut)
  always_comb begin
    wr_req   = 1'b0;
    wr_tlast = 1'b0;
    wr_tuser = sof_arm;
    if (state == ACTIVE && pend_valid) begin
      wr_req   = 1'b1;
      wr_tlast = vsync_edge || !s1_active;
    end
  end

  // frame FSM, pending slot, start-of-frame arming and sticky overflow
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= WAIT_SOF;
      pend_data  <= 16'd0;
      pend_valid <= 1'b0;
      sof_arm    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
      case (state)
        WAIT_SOF, DROP: begin
          pend_valid <= 1'b0;
          if (vsync_edge) begin
            sof_arm <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (drop) begin
            pend_valid <= 1'b0;
            state      <= DROP;
            if (vsync_edge) begin
              sof_arm <= 1'b1;
            end
          end else begin
            // a new vsync re-arms even if this cycle's write consumed the arm
            if (vsync_edge) begin
              sof_arm <= 1'b1;
            end else if (push) begin
              sof_arm <= 1'b0;
            end
            if (s1_active) begin
              pend_valid <= 1'b1;
              pend_data  <= s1_data;
            end else begin
              pend_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= WAIT_SOF;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge hclk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_tuser, wr_tlast, pend_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef VIN_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  assign frame_cnt = frame_cnt_q;

  // count frames as their start-of-frame pixel enters the FIFO
  always_ff @(posedge hclk) begin
    if (hreset) begin
      frame_cnt_q <= 16'd0;
    end else if (push && wr_tuser) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_in_2_stream.sv
// Testbench for video_in_2_stream (FIFO_DEPTH=16, VSYNC_POL=1).
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge. Expected beats are queued ahead of the stimulus and
// compared in order as they leave the stream port.
// Build with VIN_FRAME_COUNT_EN defined to include the frame counter tests.
module tb_video_in_2_stream;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_ACT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [4:0]  vin_r = '0;
  logic [4:0]  vin_g = '0;
  logic [5:0]  vin_b = '0;
  logic        vin_vsync = 1'b0;
  logic        vin_active = 1'b0;
  logic [15:0] tdata_m;
  logic        tuser_m;
  logic        tlast_m;
  logic        tvalid_m;
  logic        tready_m = 1'b1;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [4:0]  fifo_level;
`ifdef VIN_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int peak_lvl = 0;
  bit mon_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [17:0] held_beat = '0;
  logic [17:0] exp_q[$];

  video_in_2_stream #(.FIFO_DEPTH(16), .VSYNC_POL(1'b1)) dut (
    .hclk(hclk),
    .hreset(hreset),
    .vin_r(vin_r),
    .vin_g(vin_g),
    .vin_b(vin_b),
    .vin_vsync(vin_vsync),
    .vin_active(vin_active),
    .tdata_m(tdata_m),
    .tuser_m(tuser_m),
    .tlast_m(tlast_m),
    .tvalid_m(tvalid_m),
    .tready_m(tready_m),
    .overflow(overflow),
`ifdef VIN_FRAME_COUNT_EN
    .frame_cnt(frame_cnt),
`endif
    .ovf_clr(ovf_clr),
    .fifo_level(fifo_level)
  );

  // clock and watchdog
  always #5 hclk = ~hclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: in-order beats, stalled outputs held, peak occupancy
  always @(negedge hclk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
    end else begin
      if (int'(fifo_level) > peak_lvl) peak_lvl = int'(fifo_level);
      if (stall_prev)
        check("hold", {13'd0, tvalid_m, tuser_m, tlast_m, tdata_m}, {13'd0, 1'b1, held_beat});
      if (tvalid_m && tready_m) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got=%0h expected=none", {tuser_m, tlast_m, tdata_m});
        end else begin
          check("beat", {14'd0, tuser_m, tlast_m, tdata_m}, {14'd0, exp_q.pop_front()});
        end
      end
      stall_prev = tvalid_m && !tready_m;
      held_beat  = {tuser_m, tlast_m, tdata_m};
    end
  end

  // driver tasks: each step presents one cycle of video input
  task automatic step(input logic act, input logic vs, input logic [15:0] px);
    vin_active = act;
    vin_vsync  = vs;
    {vin_r, vin_g, vin_b} = px;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic frame_start();
    step(1'b0, 1'b1, 16'h0000);
    repeat (3) idle();
  endtask

  task automatic send_line(input int n, input logic [15:0] base, input logic first_user);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(first_user && i == 0), (i == n - 1), base + 16'(i)});
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, base + 16'(i));
    repeat (3) idle();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      idle();
      n++;
    end
    repeat (4) idle();
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    mon_en = 1'b0;
    hreset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < cycles; i++) begin
      tready_m = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
    end
    hreset = 1'b0;
    tready_m = 1'b1;
    idle();
    mon_en = 1'b1;
  endtask

  typedef struct {
    int         px;
    int         stall;
    logic       exp_ovf;
    int         exp_peak;
    int         exp_kept;
    logic [1:0] exp_state;
  } bp_vec_t;

  bp_vec_t tbl[5];

  initial begin
    int rx0;
    logic saw_valid;
    logic [15:0] base;

    // table: {pixels, tready-low cycles, overflow, peak level, beats kept, final state}
    tbl[0] = '{6,  0,  1'b0, 1,  6,  ST_ACT};
    tbl[1] = '{8,  12, 1'b0, 8,  8,  ST_ACT};
    tbl[2] = '{16, 30, 1'b0, 16, 16, ST_ACT};
    tbl[3] = '{17, 30, 1'b1, 16, 16, ST_DROP};
    tbl[4] = '{20, 40, 1'b1, 16, 16, ST_DROP};

    // T1: reset with random inputs, then no output before a vsync edge
    hreset = 1'b1;
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tready_m = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
    end
    check("rst_tvalid", 32'(tvalid_m), 32'd0);
    check("rst_tdata", 32'(tdata_m), 32'd0);
    check("rst_tuser_tlast", 32'({tuser_m, tlast_m}), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_WAIT));
    hreset = 1'b0;
    tready_m = 1'b1;
    idle();
    mon_en = 1'b1;
    saw_valid = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b1, 1'b0, 16'h0F00 + 16'(i));
        if (tvalid_m) saw_valid = 1'b1;
      end
      repeat (3) idle();
    end
    check("no_valid_before_sof", 32'(saw_valid), 32'd0);

    // T2: basic frame, 4 lines of 8, pixel i = 0x0100+i
    rx0 = rx_cnt;
    frame_start();
    for (int l = 0; l < 4; l++) send_line(8, 16'h0100 + 16'(8 * l), (l == 0));
    wait_drain("frame");
    check("frame_beats", 32'(rx_cnt - rx0), 32'd32);

    // T3/T4 table: one line under back-pressure per record
    for (int t = 0; t < 5; t++) begin
      base = 16'h1000 * 16'(t + 2);
      frame_start();
      for (int i = 0; i < tbl[t].exp_kept; i++)
        exp_q.push_back({(i == 0), (!tbl[t].exp_ovf && i == tbl[t].px - 1), base + 16'(i)});
      rx0 = rx_cnt;
      peak_lvl = 0;
      for (int i = 0; i < tbl[t].px + tbl[t].stall + 30; i++) begin
        tready_m = (i >= tbl[t].stall);
        step(i < tbl[t].px, 1'b0, base + 16'(i));
      end
      tready_m = 1'b1;
      wait_drain("bp");
      check("bp_kept", 32'(rx_cnt - rx0), 32'(tbl[t].exp_kept));
      check("bp_peak", 32'(peak_lvl), 32'(tbl[t].exp_peak));
      check("bp_overflow", 32'(overflow), 32'(tbl[t].exp_ovf));
      check("bp_state", 32'(dut.state), 32'(tbl[t].exp_state));
      if (tbl[t].exp_ovf) begin
        ovf_clr = 1'b1;
        idle();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
      end
    end

    // T4 sequence: overflow with coincident clear, ignored line, resync on vsync
    base = 16'h4000;
    frame_start();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 0), 1'b0, base + 16'(i)});
    tready_m = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ovf_clr = (i == 18);
      step(1'b1, 1'b0, base + 16'(i));
      if (i == 17) check("ovf_before_drop", 32'(overflow), 32'd0);
      if (i == 18) begin
        check("ovf_set_beats_clr", 32'(overflow), 32'd1);
        check("ovf_state_drop", 32'(dut.state), 32'(ST_DROP));
        check("ovf_level_full", 32'(fifo_level), 32'd16);
      end
    end
    ovf_clr = 1'b0;
    repeat (3) idle();
    tready_m = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h4800 + 16'(i));
    wait_drain("ovf");
    check("drop_still", 32'(dut.state), 32'(ST_DROP));
    frame_start();
    send_line(4, 16'h4A00, 1'b1);
    wait_drain("resume");
    check("resume_state", 32'(dut.state), 32'(ST_ACT));
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    idle();
    ovf_clr = 1'b0;
    check("ovf_clr_pulse", 32'(overflow), 32'd0);

    // T5: vsync edge arrives with the 6th pixel of a line
    base = 16'h5000;
    frame_start();
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 0 || i == 5), (i == 4 || i == 7), base + 16'(i)});
    for (int i = 0; i < 8; i++) step(1'b1, (i == 5), base + 16'(i));
    repeat (3) idle();
    wait_drain("midline_vsync");

    // mid-frame reset: everything flushed, output resumes after the next vsync
    frame_start();
    tready_m = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h6000 + 16'(i));
    mon_en = 1'b0;
    hreset = 1'b1;
    step(1'b1, 1'b0, 16'h6004);
    step(1'b1, 1'b0, 16'h6005);
    hreset = 1'b0;
    mon_en = 1'b1;
    for (int i = 6; i < 10; i++) step(1'b1, 1'b0, 16'h6000 + 16'(i));
    repeat (3) idle();
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_tvalid", 32'(tvalid_m), 32'd0);
    tready_m = 1'b1;
    frame_start();
    send_line(3, 16'h6100, 1'b1);
    wait_drain("after_reset");

`ifdef VIN_FRAME_COUNT_EN
    // T6: frame counter, including wrap from 16'hFFFF
    do_reset(4);
    check("fc_reset", 32'(frame_cnt), 32'd0);
    for (int f = 0; f < 3; f++) begin
      frame_start();
      send_line(2, 16'h7000 + 16'(16 * f), 1'b1);
    end
    wait_drain("fc");
    check("fc_three", 32'(frame_cnt), 32'd3);
    force dut.frame_cnt_q = 16'hFFFF;
    idle();
    release dut.frame_cnt_q;
    idle();
    frame_start();
    send_line(2, 16'h7100, 1'b1);
    wait_drain("fc_wrap");
    check("fc_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
